imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Registered immediate-generation stage between instruction decode and the execute operand mux.
- Selects one of several immediate formats from a 16-bit instruction and extends it to DATA_W bits.
- Supports an EXTEND prefix instruction whose 11 payload bits combine with the next instruction's 5-bit field into a full 16-bit immediate.
- Honours pipeline stall and flush.

Parameters:
- DATA_W, 16, output immediate width; must be >= 16.
- PREFIX_OP, 5'b11110, opcode in inst[15:11] that marks an EXTEND prefix.
- PREFIX_EN, 1, 1 = prefix detection enabled; 0 = prefix opcode is treated as an ordinary instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  inst/mode valid this cycle.
- inst  input  16  instruction word.
- mode  input  3  format select: 0 Z8, 1 S11, 2 S8, 3 S5, 4 S4, 5 HI8, 6-7 reserved.
- stall  input  1  hold all state and outputs.
- flush  input  1  kill in-flight output and pending prefix.
- out_valid  output  1  imm valid.
- imm  output  DATA_W  extended immediate.
- out_prefixed  output  1  imm was formed from a prefix pair.
- prefix_pending  output  1  a prefix is captured and awaiting its partner (equals state == PEND).
- prefix_err  output  1  one-cycle pulse: prefix overwrote a pending prefix.
- mode_err  output  1  one-cycle pulse: reserved mode accepted.

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, prefix register 0, state IDLE. rst overrides flush and stall.
- Latency: an accepted instruction produces imm/out_valid on the next rising edge (1 cycle).
- Formats, non-prefixed:
  - Z8: zero-extend inst[7:0].
  - S11: sign-extend inst[10:0].
  - S8: sign-extend inst[7:0].
  - S5: sign-extend inst[4:0].
  - S4: sign-extend inst[3:0].
  - HI8: {inst[7:0], 8'h00}, sign-extended from bit 15 to DATA_W.
- Reserved modes: imm = 0, out_valid = 1, mode_err pulses for 1 cycle.
- State machine: IDLE, PEND.
- IDLE:
  - in_valid with PREFIX_EN=1 and inst[15:11]==PREFIX_OP: capture inst[10:0] into pfx; next state PEND; out_valid=0 next cycle (prefix produces no output).
  - in_valid with any other instruction: normal format output; stay IDLE.
- PEND:
  - in_valid with a non-prefix instruction: imm = {pfx[10:0], inst[4:0]}; mode 0 zero-extends it, all other modes (including reserved) sign-extend from bit 15; out_prefixed=1; mode_err is not raised; next state IDLE.
  - in_valid with another prefix: pfx overwritten, prefix_err pulses, out_valid=0, stay PEND.
  - No in_valid: hold PEND indefinitely.
- out_valid=0 in any cycle following an edge with in_valid=0 (and no stall).
- out_prefixed, prefix_err and mode_err clear on the next non-stalled edge.
- Stall (stall=1, flush=0): every register holds, including out_valid, imm, the flags, state and pfx; in_valid is ignored.
- Flush: takes priority over stall and in_valid. On the next edge: out_valid=0, out_prefixed=0, error pulses=0, state=IDLE; pfx is not cleared, but its value is don't-care. The instruction presented on the flush cycle is discarded.
- imm holds its last value when out_valid=0, except after reset (0).

Test Plan:
- DATA_W=16; in_valid=1, inst=16'h00F3, mode=2 (S8) -> next cycle out_valid=1, imm=16'hFFF3; mode=0 (Z8) -> imm=16'h00F3; mode=5 (HI8) -> imm=16'hF300.
- Prefix pair: inst=16'hF123 (pfx=11'h123), then inst=16'h4C05 with mode=3 -> out_valid=0 after the first, then imm=16'h2465, out_prefixed=1, state IDLE. With DATA_W=32 and pfx=11'h7FF, inst[4:0]=5'h1F -> imm=32'hFFFFFFFF.
- Double prefix: F123 then F7FF -> prefix_err pulses 1 cycle, prefix_pending stays 1, out_valid=0. Next inst=16'h0001 with mode=3 -> imm=16'hFFE1.
- Prefix then flush: F123, flush=1 with inst=16'h0005 -> out_valid=0, prefix_pending=0. Next inst=16'h0005, mode=3 -> imm=16'h0005, out_prefixed=0.
- Stall: after imm=16'hFFF3 is valid, hold stall=1 for 3 cycles with changing inst -> imm/out_valid unchanged. Assert stall and flush together -> out_valid=0.
- Reset/reserved: mode=6 -> imm=0, mode_err pulses 1 cycle. rst asserted while state PEND -> all outputs 0, prefix_pending=0 on the next edge.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator with EXTEND-prefix pairing; 1-cycle latency.
// stall freezes every register; flush drops the output and any pending prefix.
module imm_ext_pipe #(
    parameter int           DATA_W    = 16,
    parameter logic [4:0]   PREFIX_OP = 5'b11110,
    parameter bit           PREFIX_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       inst,
    input  logic [2:0]        mode,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] imm,
    output logic              out_prefixed,
    output logic              prefix_pending,
    output logic              prefix_err,
    output logic              mode_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]        state;
    logic [10:0]       pfx;
    logic [15:0]       norm16;
    logic              mode_rsv;
    logic              is_pfx;
    logic [15:0]       pair16;
    logic [DATA_W-1:0] norm_imm;
    logic [DATA_W-1:0] pair_imm;

    assign is_pfx = PREFIX_EN && (inst[15:11] == PREFIX_OP);

    // Every format is expressed as a 16-bit value whose bit 15 already
    // carries the sign (zero for Z8 and reserved), so one sign-extension suffices.
    always_comb begin
        norm16   = 16'h0000;
        mode_rsv = 1'b0;
        case (mode)
            3'd0:    norm16 = {8'h00, inst[7:0]};
            3'd1:    norm16 = {{5{inst[10]}}, inst[10:0]};
            3'd2:    norm16 = {{8{inst[7]}}, inst[7:0]};
            3'd3:    norm16 = {{11{inst[4]}}, inst[4:0]};
            3'd4:    norm16 = {{12{inst[3]}}, inst[3:0]};
            3'd5:    norm16 = {inst[7:0], 8'h00};
            default: mode_rsv = 1'b1;
        endcase
    end

    assign norm_imm = DATA_W'($signed(norm16));
    assign pair16   = {pfx, inst[4:0]};
    assign pair_imm = (mode == 3'd0) ? DATA_W'(pair16) : DATA_W'($signed(pair16));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pfx          <= '0;
            out_valid    <= 1'b0;
            imm          <= '0;
            out_prefixed <= 1'b0;
            prefix_err   <= 1'b0;
            mode_err     <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            out_prefixed <= 1'b0;
            prefix_err   <= 1'b0;
            mode_err     <= 1'b0;
        end else if (!stall) begin
            out_valid    <= 1'b0;
            out_prefixed <= 1'b0;
            prefix_err   <= 1'b0;
            mode_err     <= 1'b0;
            if (in_valid) begin
                if (is_pfx) begin
                    pfx        <= inst[10:0];
                    prefix_err <= (state == PEND);
                    state      <= PEND;
                end else if (state == PEND) begin
                    imm          <= pair_imm;
                    out_valid    <= 1'b1;
                    out_prefixed <= 1'b1;
                    state        <= IDLE;
                end else begin
                    imm       <= norm_imm;
                    out_valid <= 1'b1;
                    mode_err  <= mode_rsv;
                end
            end
        end
    end

    assign prefix_pending = (state == PEND);

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe; a 16-bit and a 32-bit instance share stimulus.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] inst;
    logic [2:0]  mode;
    logic        stall;
    logic        flush;

    logic        ov16, pf16, pp16, pe16, me16;
    logic [15:0] imm16;
    logic        ov32, pf32, pp32, pe32, me32;
    logic [31:0] imm32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.DATA_W(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .mode(mode),
        .stall(stall), .flush(flush), .out_valid(ov16), .imm(imm16),
        .out_prefixed(pf16), .prefix_pending(pp16), .prefix_err(pe16), .mode_err(me16)
    );

    imm_ext_pipe #(.DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .mode(mode),
        .stall(stall), .flush(flush), .out_valid(ov32), .imm(imm32),
        .out_prefixed(pf32), .prefix_pending(pp32), .prefix_err(pe32), .mode_err(me32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] i, input logic [2:0] m);
        in_valid = v;
        inst     = i;
        mode     = m;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; inst = 16'hF123; mode = 3'd0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        check("rst_ov", 32'(ov16), 32'd0);
        check("rst_imm", 32'(imm16), 32'd0);
        check("rst_pend", 32'(pp16), 32'd0);
        check("rst_flags", {29'd0, pf16, pe16, me16}, 32'd0);
        rst = 1'b0;

        drive(1'b1, 16'h00F3, 3'd2);
        check("s8_ov", 32'(ov16), 32'd1);
        check("s8_imm", 32'(imm16), 32'h0000FFF3);
        check("s8_imm32", imm32, 32'hFFFFFFF3);
        drive(1'b1, 16'h00F3, 3'd0);
        check("z8_imm", 32'(imm16), 32'h000000F3);
        check("z8_imm32", imm32, 32'h000000F3);
        drive(1'b1, 16'h00F3, 3'd5);
        check("hi8_imm", 32'(imm16), 32'h0000F300);
        check("hi8_imm32", imm32, 32'hFFFFF300);
        drive(1'b1, 16'h0400, 3'd1);
        check("s11_imm", 32'(imm16), 32'h0000FC00);
        drive(1'b1, 16'h0018, 3'd4);
        check("s4_imm", 32'(imm16), 32'h0000FFF8);

        // Prefix pair
        drive(1'b1, 16'hF123, 3'd3);
        check("pfx_ov", 32'(ov16), 32'd0);
        check("pfx_pend", 32'(pp16), 32'd1);
        check("pfx_imm_hold", 32'(imm16), 32'h0000FFF8);
        drive(1'b1, 16'h4C05, 3'd3);
        check("pair_ov", 32'(ov16), 32'd1);
        check("pair_imm", 32'(imm16), 32'h00002465);
        check("pair_pfxd", 32'(pf16), 32'd1);
        check("pair_pend", 32'(pp16), 32'd0);

        drive(1'b1, 16'hF7FF, 3'd3);
        drive(1'b1, 16'h001F, 3'd3);
        check("pair32_sx", imm32, 32'hFFFFFFFF);
        check("pair16_sx", 32'(imm16), 32'h0000FFFF);
        drive(1'b1, 16'hF7FF, 3'd3);
        drive(1'b1, 16'h001F, 3'd0);
        check("pair32_zx", imm32, 32'h0000FFFF);

        // Double prefix
        drive(1'b1, 16'hF123, 3'd3);
        check("dbl_perr0", 32'(pe16), 32'd0);
        drive(1'b1, 16'hF7FF, 3'd3);
        check("dbl_perr1", 32'(pe16), 32'd1);
        check("dbl_pend", 32'(pp16), 32'd1);
        check("dbl_ov", 32'(ov16), 32'd0);
        drive(1'b1, 16'h0001, 3'd3);
        check("dbl_imm", 32'(imm16), 32'h0000FFE1);
        check("dbl_perr_clr", 32'(pe16), 32'd0);
        check("dbl_pfxd", 32'(pf16), 32'd1);

        // Reserved mode paired with a prefix raises no mode_err
        drive(1'b1, 16'hF7FF, 3'd3);
        drive(1'b1, 16'h0005, 3'd7);
        check("rsv_pair_imm", 32'(imm16), 32'h0000FFE5);
        check("rsv_pair_merr", 32'(me16), 32'd0);

        // Prefix then flush
        drive(1'b1, 16'hF123, 3'd3);
        flush = 1'b1;
        drive(1'b1, 16'h0005, 3'd3);
        flush = 1'b0;
        check("flush_ov", 32'(ov16), 32'd0);
        check("flush_pend", 32'(pp16), 32'd0);
        drive(1'b1, 16'h0005, 3'd3);
        check("postflush_imm", 32'(imm16), 32'h00000005);
        check("postflush_pfxd", 32'(pf16), 32'd0);

        drive(1'b0, 16'h00FF, 3'd0);
        check("idle_ov", 32'(ov16), 32'd0);
        check("idle_imm_hold", 32'(imm16), 32'h00000005);

        // Stall
        drive(1'b1, 16'h00F3, 3'd2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hF123 + 16'(k), 3'd0);
            check("stall_imm", 32'(imm16), 32'h0000FFF3);
            check("stall_ov", 32'(ov16), 32'd1);
            check("stall_pend", 32'(pp16), 32'd0);
        end
        flush = 1'b1;
        drive(1'b1, 16'h0001, 3'd0);
        flush = 1'b0;
        stall = 1'b0;
        check("stallflush_ov", 32'(ov16), 32'd0);
        check("stallflush_imm", 32'(imm16), 32'h0000FFF3);

        // Reserved mode
        drive(1'b1, 16'h00F3, 3'd6);
        check("rsv_ov", 32'(ov16), 32'd1);
        check("rsv_imm", 32'(imm16), 32'd0);
        check("rsv_merr", 32'(me16), 32'd1);
        stall = 1'b1;
        drive(1'b1, 16'h00F3, 3'd2);
        check("rsv_merr_stall", 32'(me16), 32'd1);
        stall = 1'b0;
        drive(1'b0, 16'h00F3, 3'd6);
        check("rsv_merr_clr", 32'(me16), 32'd0);
        check("rsv_ov_clr", 32'(ov16), 32'd0);

        // Reset while pending
        drive(1'b1, 16'hF123, 3'd3);
        check("rstp_pend", 32'(pp16), 32'd1);
        rst = 1'b1;
        drive(1'b1, 16'h4C05, 3'd3);
        rst = 1'b0;
        check("rstp_pend0", 32'(pp16), 32'd0);
        check("rstp_ov", 32'(ov16), 32'd0);
        check("rstp_imm", 32'(imm16), 32'd0);
        check("rstp_imm32", imm32, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
